u_lsu: RTL and testbench

Data-side load/store unit. It sits between the execute stage and a private word-organised data RAM, and is the responder end of the lsu_a/lsu_we/lsu_wd/lsu_re -> lsu_vld/lsu_rd interface. Requests arrive as single-cycle, fire-and-forget strobes; the execute stage never stalls. They are queued in order, serviced after a configurable number of wait states, and every load returns exactly one lsu_vld pulse.

---
 rtl/u_lsu_pkg.sv | 28 ++
 rtl/u_lsu_fifo.sv | 53 +++++
 rtl/u_lsu.sv | 116 +++++++++++
 tb/tb_u_lsu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/u_lsu_pkg.sv
// Shared types and lane-mask helpers for the load/store unit.
package u_lsu_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACC} lsu_st_e;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  mask;
        logic [31:0] wd;
        logic        is_st;
    } lsu_req_t;

    // Byte, aligned halfword and full word are the only lane patterns.
    function automatic logic mask_legal(input logic [3:0] mask);
        case (mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lane_expand(input logic [3:0] mask);
        logic [31:0] bm;
        for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{mask[i]}};
        return bm;
    endfunction

endpackage

// File: rtl/u_lsu_fifo.sv
// In-order request queue; a push into a full queue is accepted when a pop frees a slot in the same cycle.
module u_lsu_fifo
    import u_lsu_pkg::*;
#(
    parameter int FIFO_D = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  lsu_req_t din,
    input  logic     pop,
    output lsu_req_t dout,
    output logic     full,
    output logic     empty,
    output logic     ovf
);
    localparam int PW = $clog2(FIFO_D);

    lsu_req_t        mem [FIFO_D];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic            wr_en, rd_en;

    assign full  = (count == (PW+1)'(FIFO_D));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign ovf   = push && !wr_en;
    assign dout  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage arrays are left unreset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/u_lsu.sv
// Load/store unit: queues fire-and-forget requests and services them in order against a private word RAM.
module u_lsu
    import u_lsu_pkg::*;
#(
    parameter int AW     = 10,
    parameter int FIFO_D = 4,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] lsu_a,
    input  logic [3:0]  lsu_we,
    input  logic [31:0] lsu_wd,
    input  logic [3:0]  lsu_re,
    output logic        lsu_vld,
    output logic [31:0] lsu_rd,
    output logic        busy,
    output logic        err_ovf,
    output logic        err_mis
);
    lsu_req_t    req, head, cur;
    logic        push, pop, full, empty, ovf;
    lsu_st_e     state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] ram [2**AW];
    logic [31:0] rd_word;
    logic [3:0]  rd_mask;
    logic [AW-1:0] idx;
    logic        unused_addr_bits;

    // Store wins when both enables are set in the same cycle.
    always_comb begin
        push      = (|lsu_we) || (|lsu_re);
        req.is_st = |lsu_we;
        req.mask  = req.is_st ? lsu_we : lsu_re;
        req.a     = lsu_a;
        req.wd    = lsu_wd;
    end

    u_lsu_fifo #(.FIFO_D(FIFO_D)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (req),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .ovf   (ovf)
    );

    // WAIT the parameter shadows the enum literal, so states are package-qualified.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pop      = 1'b0;
        case (state)
            u_lsu_pkg::IDLE: if (!empty) begin
                pop      = 1'b1;
                cnt_nx   = 4'(WAIT);
                state_nx = (WAIT > 0) ? u_lsu_pkg::WAIT : u_lsu_pkg::ACC;
            end
            u_lsu_pkg::WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt <= 4'd1) state_nx = u_lsu_pkg::ACC;
            end
            u_lsu_pkg::ACC: state_nx = u_lsu_pkg::IDLE;
            default:        state_nx = u_lsu_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= u_lsu_pkg::IDLE;
            cnt     <= '0;
            cur     <= '0;
            lsu_vld <= 1'b0;
            rd_mask <= '0;
            err_ovf <= 1'b0;
            err_mis <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            if (pop) cur <= head;
            lsu_vld <= (state == u_lsu_pkg::ACC) && !cur.is_st;
            if (state == u_lsu_pkg::ACC && !cur.is_st)
                rd_mask <= mask_legal(cur.mask) ? cur.mask : 4'b0000;
            err_ovf <= err_ovf | ovf;
            err_mis <= err_mis | (push && !mask_legal(req.mask));
        end
    end

    assign idx = cur.a[AW+1:2];

    // Writes happen only in ACC, so a reset can never leave a half-written word.
    always_ff @(posedge clk) begin
        if (state == u_lsu_pkg::ACC) begin
            if (cur.is_st) begin
                if (mask_legal(cur.mask)) begin
                    for (int i = 0; i < 4; i++)
                        if (cur.mask[i]) ram[idx][8*i +: 8] <= cur.wd[8*i +: 8];
                end
            end else begin
                rd_word <= ram[idx];
            end
        end
    end

    // rd_mask is reset and only moves on loads, so lsu_rd is zero after reset and holds between pulses.
    assign lsu_rd = rd_word & lane_expand(rd_mask);
    assign busy   = !empty || (state != u_lsu_pkg::IDLE);

    assign unused_addr_bits = &{1'b0, cur.a[31:AW+2], cur.a[1:0]};

endmodule

// File: tb/tb_u_lsu.sv
// Directed self-checking bench for u_lsu with a scoreboard of expected load results.
module tb_u_lsu;
    localparam int AW     = 10;
    localparam int FIFO_D = 4;
    localparam int WAIT   = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] lsu_a, lsu_wd, lsu_rd;
    logic [3:0]  lsu_we, lsu_re;
    logic        lsu_vld, busy, err_ovf, err_mis;

    typedef struct { logic [31:0] rd; int due; } exp_t;
    exp_t sb [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int vld_cnt = 0;

    u_lsu #(.AW(AW), .FIFO_D(FIFO_D), .WAIT(WAIT)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .lsu_a   (lsu_a),
        .lsu_we  (lsu_we),
        .lsu_wd  (lsu_wd),
        .lsu_re  (lsu_re),
        .lsu_vld (lsu_vld),
        .lsu_rd  (lsu_rd),
        .busy    (busy),
        .err_ovf (err_ovf),
        .err_mis (err_mis)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every lsu_vld pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstn === 1'b1 && lsu_vld === 1'b1) begin
            exp_t e;
            vld_cnt++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL vld_unexpected observed=pulse expected=none rd=%h", lsu_rd);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("load_data", lsu_rd, e.rd);
                if (e.due >= 0) check("load_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // One request cycle; called at posedge+1, returns at the next posedge+1.
    task automatic req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input logic [3:0] re);
        lsu_a = a; lsu_we = we; lsu_wd = wd; lsu_re = re;
        @(posedge clk); #1;
        lsu_we = '0; lsu_re = '0; lsu_wd = '0; lsu_a = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        req(a, we, wd, 4'b0000);
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] re, input logic [31:0] exp,
                        input bit chk_lat);
        exp_t e;
        e.rd  = exp;
        e.due = chk_lat ? cyc + 3 + WAIT : -1;
        sb.push_back(e);
        req(a, 4'b0000, 32'h0, re);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk); #1;
            if (!busy && sb.size() == 0) done = 1'b1;
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s_timeout observed=busy expected=idle pending=%0d", tag, sb.size());
        end
        sb.delete();
    endtask

    initial begin
        int v0;
        rstn = 1'b0; lsu_a = '0; lsu_we = '0; lsu_wd = '0; lsu_re = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", {31'b0, lsu_vld}, 32'd0);
        check("rst_rd", lsu_rd, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ovf", {31'b0, err_ovf}, 32'd0);
        check("rst_mis", {31'b0, err_mis}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Full-word store then load, with exact response latency from an idle unit.
        store(32'h0000_1000, 4'b1111, 32'hDEAD_BEEF);
        check("busy_after_req", {31'b0, busy}, 32'd1);
        wait_idle("st1");
        load(32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 1'b1);
        wait_idle("ld1");

        // Byte-lane store merged into the word; various lane reads, issued back to back.
        store(32'h0000_1000, 4'b0010, 32'h0000_AA00);
        load(32'h0000_1000, 4'b1111, 32'hDEAD_AAEF, 1'b0);
        load(32'h0000_1000, 4'b0011, 32'h0000_AAEF, 1'b0);
        wait_idle("lanes_a");
        load(32'h0000_1000, 4'b1100, 32'hDEAD_0000, 1'b0);
        load(32'h0000_1003, 4'b0001, 32'h0000_00EF, 1'b0);
        load(32'h0000_1000, 4'b1000, 32'hDE00_0000, 1'b0);
        wait_idle("lanes_b");

        // Address aliasing modulo RAM size, both directions and with high bits set.
        store(32'h0000_1000 + 4*(2**AW), 4'b1111, 32'hCAFE_F00D);
        load(32'h0000_1000, 4'b1111, 32'hCAFE_F00D, 1'b0);
        store(32'h0000_1000, 4'b1111, 32'hDEAD_AAEF);
        load(32'h0000_1000 + 4*(2**AW), 4'b1111, 32'hDEAD_AAEF, 1'b0);
        load(32'hFFFF_1000, 4'b1111, 32'hDEAD_AAEF, 1'b0);
        wait_idle("alias");

        // Overflow: preload 8 words, then 8 loads on consecutive cycles.
        for (int i = 1; i <= 8; i++) begin
            store(32'h0000_1000 + 32'(4*i), 4'b1111, 32'h1111_1111 * 32'(i));
            wait_idle("preload");
        end
        check("ovf_before", {31'b0, err_ovf}, 32'd0);
        v0 = vld_cnt;
        // With WAIT=2 the queue absorbs six back-to-back requests; the 7th and 8th arrive
        // while full and with the FSM mid-access, so they are dropped.
        for (int i = 1; i <= 8; i++) begin
            if (i <= 6) begin
                load(32'h0000_1000 + 32'(4*i), 4'b1111, 32'h1111_1111 * 32'(i), 1'b0);
            end else begin
                req(32'h0000_1000 + 32'(4*i), 4'b0000, 32'h0, 4'b1111);
            end
        end
        wait_idle("ovf");
        check("ovf_set", {31'b0, err_ovf}, 32'd1);
        check("ovf_vld_count", 32'(vld_cnt - v0), 32'd6);

        // Illegal lane masks: store writes nothing, load returns zero data.
        check("mis_before", {31'b0, err_mis}, 32'd0);
        store(32'h0000_1000, 4'b0101, 32'hFFFF_FFFF);
        load(32'h0000_1000, 4'b1111, 32'hDEAD_AAEF, 1'b0);
        load(32'h0000_1000, 4'b0110, 32'h0000_0000, 1'b0);
        wait_idle("mis");
        check("mis_set", {31'b0, err_mis}, 32'd1);
        check("ovf_sticky", {31'b0, err_ovf}, 32'd1);

        // Reset mid-access: queued loads vanish, flags clear, RAM survives.
        req(32'h0000_1000, 4'b0000, 32'h0, 4'b1111);
        req(32'h0000_1004, 4'b0000, 32'h0, 4'b1111);
        req(32'h0000_1008, 4'b0000, 32'h0, 4'b1111);
        v0 = vld_cnt;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst2_busy", {31'b0, busy}, 32'd0);
        check("rst2_ovf", {31'b0, err_ovf}, 32'd0);
        check("rst2_mis", {31'b0, err_mis}, 32'd0);
        check("rst2_rd", lsu_rd, 32'h0);
        rstn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("rst2_no_vld", 32'(vld_cnt - v0), 32'd0);
        check("rst2_busy_after", {31'b0, busy}, 32'd0);
        load(32'h0000_1000, 4'b1111, 32'hDEAD_AAEF, 1'b1);
        wait_idle("post_rst");
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
